dm_cache: RTL and testbench
===========================

Name: dm_cache

Overview:
- Direct-mapped, write-back, write-allocate cache between a 32-bit word-addressed processor port and a slow 128-bit line-addressed memory.
- Holds 8 blocks of 4 words each.
- A hit completes in the same cycle with no stall.
- A miss stalls the processor while a dirty victim is written back (if needed) and the missing line is fetched.

Parameters:
- none; geometry is fixed: 8 blocks, 4 × 32-bit words per block, 128-bit memory line.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- proc_reset  in  1  reset; asynchronous and active-low (0 = reset)
- proc_read  in  1  processor read request
- proc_write  in  1  processor write request
- proc_addr  in  30  word address: [1:0] word offset, [4:2] index, [29:5] tag (25 b)
- proc_rdata  out  32  read data
- proc_wdata  in  32  write data
- proc_stall  out  1  1 = request not completed this cycle; processor holds its request
- mem_read  out  1  memory line read request
- mem_write  out  1  memory line write request
- mem_addr  out  28  line address
- mem_rdata  in  128  line read data; word w at bits [32w+31:32w]
- mem_wdata  out  128  line write data, same packing
- mem_ready  in  1  memory completed current request (valid in the cycle it is high)

Behaviour:
- Storage per block: valid, dirty, 25-bit tag, 128-bit data.
- Reset (proc_reset=0, asynchronous):
  - all valid=0, dirty=0; state=COMPARE.
  - mem_read=mem_write=0.
  - Data and tag contents are don't-care.
  - Reset mid-miss aborts the transfer immediately; dirty data is lost.
- hit = valid[idx] && tag[idx]==proc_addr[29:5].
- Request = proc_read | proc_write. If both are asserted, the request is treated as a write.
- proc_stall (combinational) = request && !(state==COMPARE && hit). It is 0 when there is no request and during reset.
- proc_rdata (combinational) = word proc_addr[1:0] of block idx on a read hit, otherwise 0.
- State COMPARE:
  - Read hit: data returned in the same cycle, no state change.
  - Write hit: at clk edge, write proc_wdata into that word and set dirty=1; proc_stall=0 in that cycle.
  - Miss with victim valid&&dirty: go to WRITEBACK.
  - Other misses: go to ALLOCATE.
  - No request: stay; no memory activity.
- State WRITEBACK:
  - mem_write=1, mem_addr={tag[idx],idx}, mem_wdata=data[idx], held stable.
  - On the clk edge where mem_ready=1: dirty[idx]=0, go to ALLOCATE.
- State ALLOCATE:
  - mem_read=1, mem_addr=proc_addr[29:2], held stable.
  - On the clk edge where mem_ready=1: data[idx]=mem_rdata, tag[idx]=proc_addr[29:5], valid=1, dirty=0, go to COMPARE.
  - The request then hits on the next cycle; a write hit merges proc_wdata at that point.
- Memory handshake:
  - mem_read and mem_write are never both 1.
  - A request stays asserted until mem_ready is sampled high, then is deasserted or switched to the next operation at that same edge.
  - No assumption is made on memory latency.
- Miss latency = writeback latency (if dirty) + fetch latency + 1 compare cycle.
- The processor holds proc_addr, proc_wdata and its command constant while proc_stall=1. A changed request mid-miss is not supported.

Test Plan:
- Reset: hold proc_reset=0 four cycles with no request -> proc_stall=0, mem_read=mem_write=0; all subsequent first accesses miss.
- Sequential read: memory line i holds words 4i..4i+3. Read addresses 0..1023 -> each returns data==address. Stall occurs only on offset-0 access of each line, with no mem_write since all lines are clean.
- Sequential write: write addresses 0..1023 with data 3k+1 -> lines are write-allocated. Each evicted dirty line is written back before the fetch, e.g. the miss at address 32 writes back mem_addr 0 with words {1,4,7,10}, then reads mem_addr 8.
- Read-back: read addresses 0..1023 -> each returns 3k+1, including lines resident in the cache (dirty) and lines previously written back.
- Conflict: write 0xAAAA at addr 5, read addr 37 (same index 1, different tag) -> writeback of line 1, then fetch of line 9; read addr 37 returns 37 (preloaded). Reading addr 5 afterwards returns 0xAAAA.
- Async reset during ALLOCATE -> mem_read drops immediately without waiting for clk; the next access to that line misses.

Source files
------------

// File: rtl/dm_cache.sv
// dm_cache: direct-mapped write-back write-allocate cache, 8 blocks x 4 words, 128-bit memory lines
module dm_cache (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    output logic [31:0]  proc_rdata,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    input  logic [127:0] mem_rdata,
    output logic [127:0] mem_wdata,
    input  logic         mem_ready
);
    typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;
    state_t state, state_next;
    logic [127:0] data [8];
    logic [24:0]  tags [8];
    logic [7:0]   valid, dirty;
    logic [2:0]   idx;
    logic [1:0]   off;
    logic [24:0]  tag;
    logic         req, hit, write_hit, fill, flushed;
    assign idx       = proc_addr[4:2];
    assign off       = proc_addr[1:0];
    assign tag       = proc_addr[29:5];
    assign req       = proc_read | proc_write;
    assign hit       = valid[idx] && tags[idx] == tag;
    assign write_hit = state == COMPARE && hit && proc_write;
    assign fill      = state == ALLOCATE && mem_ready;
    assign flushed   = state == WRITEBACK && mem_ready;

    // state register; reset aborts any memory transfer in flight
    always_ff @(posedge clk or negedge proc_reset) begin
        if (!proc_reset) state <= COMPARE;
        else state <= state_next;
    end

    // next state: a miss evicts a dirty victim first, then fetches the line
    always_comb begin
        state_next = state == COMPARE   ? (req && !hit ? (valid[idx] && dirty[idx] ? WRITEBACK : ALLOCATE) : COMPARE) :
                     state == WRITEBACK ? (mem_ready ? ALLOCATE : WRITEBACK) :
                                          (mem_ready ? COMPARE : ALLOCATE);
    end

    // outputs: memory requests follow the state, processor side is combinational on hit
    always_comb begin
        mem_write  = state == WRITEBACK;
        mem_read   = state == ALLOCATE;
        mem_addr   = state == WRITEBACK ? {tags[idx], idx} : proc_addr[29:2];
        mem_wdata  = data[idx];
        proc_stall = proc_reset && req && !(state == COMPARE && hit);
        proc_rdata = (state == COMPARE && hit && proc_read && !proc_write) ? data[idx][{off, 5'b0} +: 32] : '0;
    end

    // data and tag arrays: line fill from memory or single-word write hit
    always_ff @(posedge clk) begin
        if (fill) begin
            data[idx] <= mem_rdata;
            tags[idx] <= tag;
        end else if (write_hit) begin
            data[idx][{off, 5'b0} +: 32] <= proc_wdata;
        end
    end

    // valid/dirty bits; cleared on reset so cached dirty data is dropped
    always_ff @(posedge clk or negedge proc_reset) begin
        if (!proc_reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (flushed) begin
            dirty[idx] <= 1'b0;
        end else if (write_hit) begin
            dirty[idx] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dm_cache.sv
// tb_dm_cache: randomized and directed checks of dm_cache against a word-level reference model
module tb_dm_cache;
    logic         clk = 0;
    logic         proc_reset = 0;
    logic         proc_read = 0;
    logic         proc_write = 0;
    logic [29:0]  proc_addr = '0;
    logic [31:0]  proc_rdata;
    logic [31:0]  proc_wdata = '0;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_rdata = '0;
    logic [127:0] mem_wdata;
    logic         mem_ready = 0;

    int n_chk = 0;
    int n_fail = 0;

    logic [127:0] mem_lines [int];
    logic [31:0]  ref_words [int];
    int           wb_addr_q [$];
    logic [127:0] wb_data_q [$];
    int           rd_q [$];
    bit           m_valid [8];
    bit           m_dirty [8];
    int           m_tag [8];

    dm_cache dut (
        .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_rdata(proc_rdata), .proc_wdata(proc_wdata), .proc_stall(proc_stall),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] line_of(int a);
        logic [127:0] v;
        if (mem_lines.exists(a)) return mem_lines[a];
        for (int w = 0; w < 4; w++) v[w*32 +: 32] = 32'(4 * a + w);
        return v;
    endfunction

    function automatic logic [31:0] ref_word(int a);
        return ref_words.exists(a) ? ref_words[a] : 32'(a);
    endfunction

    // slow memory: random latency of 0..3 extra cycles per request
    initial begin
        int cnt = 0;
        int lat = 1;
        forever begin
            @(negedge clk);
            mem_ready = 0;
            if (mem_read || mem_write) check("mem_mutex", {mem_read, mem_write} == 2'b11, 0);
            if (!(mem_read || mem_write)) cnt = 0;
            else if (cnt >= lat) begin
                mem_ready = 1;
                if (mem_write) begin
                    mem_lines[int'(mem_addr)] = mem_wdata;
                    wb_addr_q.push_back(int'(mem_addr));
                    wb_data_q.push_back(mem_wdata);
                end else begin
                    mem_rdata = line_of(int'(mem_addr));
                    rd_q.push_back(int'(mem_addr));
                end
                cnt = 0;
                lat = $urandom_range(0, 3);
            end else cnt++;
        end
    end

    task automatic access(input logic rd, input logic wr, input int a, input logic [31:0] wd, input string name);
        int idx = (a >> 2) & 7;
        int t = a >> 5;
        bit miss = !(m_valid[idx] && m_tag[idx] == t);
        bit wb = miss && m_valid[idx] && m_dirty[idx];
        int wb0 = wb_addr_q.size();
        int n = 0;
        proc_read = rd;
        proc_write = wr;
        proc_addr = 30'(a);
        proc_wdata = wd;
        #1;
        while (proc_stall && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("stall_done", proc_stall, 0);
        check("miss", n != 0, miss);
        check("writeback", wb_addr_q.size() - wb0, wb);
        if (wr) begin
            check("wr_rdata", proc_rdata, 0);
            ref_words[a] = wd;
        end else check(name, proc_rdata, ref_word(a));
        if (miss) begin
            m_valid[idx] = 1;
            m_tag[idx] = t;
            m_dirty[idx] = 0;
        end
        if (wr) m_dirty[idx] = 1;
        @(negedge clk);
        proc_read = 0;
        proc_write = 0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
            m_tag[i] = 0;
        end
        repeat (4) @(negedge clk);
        #1;
        check("rst_stall", proc_stall, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        proc_read = 1;
        #1;
        check("rst_stall_req", proc_stall, 0);
        proc_read = 0;
        @(negedge clk);
        proc_reset = 1;
        @(negedge clk);

        for (int k = 0; k < 1024; k++) access(1, 0, k, 0, "seq_rd");

        access(0, 1, 5, 32'hAAAA, "conf_wr");
        access(1, 0, 37, 0, "conf_rd37");
        check("conf_wb_addr", wb_addr_q[$], 1);
        check("conf_rd_addr", rd_q[$], 9);
        access(1, 0, 5, 0, "conf_rd5");

        for (int k = 0; k < 1024; k++) begin
            access(0, 1, k, 32'(3 * k + 1), "seq_wr");
            if (k == 32) begin
                check("wb32_addr", wb_addr_q[$], 0);
                check("wb32_data", wb_data_q[$], {32'd10, 32'd7, 32'd4, 32'd1});
                check("rd32_addr", rd_q[$], 8);
            end
        end
        for (int k = 0; k < 1024; k++) access(1, 0, k, 0, "readback");

        proc_read = 1;
        proc_addr = 30'd5;
        n = 0;
        while (!mem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("alloc_reached", mem_read, 1);
        #2;
        proc_reset = 0;
        #1;
        check("async_mem_read", mem_read, 0);
        check("async_mem_write", mem_write, 0);
        check("async_stall", proc_stall, 0);
        for (int i = 0; i < 8; i++) m_valid[i] = 0;
        @(negedge clk);
        proc_read = 0;
        @(negedge clk);
        proc_reset = 1;
        @(negedge clk);
        access(1, 0, 5, 0, "post_rst_rd");

        for (int i = 0; i < 400; i++) begin
            int op = $urandom_range(0, 3);
            access(op != 2, op >= 2, $urandom_range(0, 255), $urandom, "rand_rd");
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
